// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV M-extension multiply/divide unit beside the execute-stage ALU.
// Latency: MUL* XLEN/MUL_BITS_PER_CYCLE edges, DIV*/REM* XLEN edges; divide-by-zero and signed overflow skip CALC.
// Backpressure: ready_out low from accept until the result is taken; DONE holds while ready_in=0. Option macro: MULDIV_WORD_OPS_EN (RV64 *W ops).
module muldiv_unit #(
    parameter int XLEN               = 64,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [2:0]      op_in,
    input  logic            word_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic            flush_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] result_out,
    output logic            non_zero_out,
    output logic            busy_out
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [CW-1:0] ITER_MUL = CW'(XLEN / MUL_BITS_PER_CYCLE);
    localparam logic [CW-1:0] ITER_DIV = CW'(XLEN);

    // Control state
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    // Multiply datapath: shifting multiplicand, shifting multiplier (or fixed divisor), product
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    // Divide datapath: partial remainder and dividend/quotient shift register
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   result_q, result_d;

`ifdef MULDIV_WORD_OPS_EN
    logic              word_q, word_d;
`else
    logic              word_unused;
    assign word_unused = word_in;
`endif

    // Operand conditioning for the accept edge
    logic              s1_signed, s2_signed;
    logic [XLEN-1:0]   a_ext, b_ext;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   min_val;
    logic              div_zero, div_ovf;
    logic [CW-1:0]     iter;
    logic [XLEN-1:0]   quo_init;
    logic [XLEN-1:0]   special_res;

    // Per-step arithmetic
    logic [2*XLEN-1:0] mul_sum;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;
    logic [XLEN-1:0]   quo_fin;
    logic [XLEN-1:0]   rem_fin;
    logic [XLEN-1:0]   calc_res;

    // Decode the incoming op: sign-extend/zero-extend, take magnitudes, detect special cases
    always_comb begin
        s1_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
        s2_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_ext     = rs1_value_in;
        b_ext     = rs2_value_in;
        min_val   = {1'b1, {(XLEN-1){1'b0}}};
        iter      = op_in[2] ? ITER_DIV : ITER_MUL;
`ifdef MULDIV_WORD_OPS_EN
        if (word_in) begin
            a_ext   = s1_signed ? {{(XLEN-32){rs1_value_in[31]}}, rs1_value_in[31:0]}
                                : {{(XLEN-32){1'b0}}, rs1_value_in[31:0]};
            b_ext   = s2_signed ? {{(XLEN-32){rs2_value_in[31]}}, rs2_value_in[31:0]}
                                : {{(XLEN-32){1'b0}}, rs2_value_in[31:0]};
            min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
            iter    = op_in[2] ? CW'(32) : CW'(32 / MUL_BITS_PER_CYCLE);
        end
`endif
        a_neg    = s1_signed & a_ext[XLEN-1];
        b_neg    = s2_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
        quo_init = a_mag;
`ifdef MULDIV_WORD_OPS_EN
        // Word divides run 32 steps, so the dividend starts in the top half
        if (word_in) begin
            quo_init = {a_mag[31:0], {(XLEN-32){1'b0}}};
        end
`endif
        div_zero = op_in[2] && (b_ext == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (a_ext == min_val) && (b_ext == '1);
        if (div_zero) begin
            special_res = op_in[1] ? a_ext : '1;
        end else begin
            special_res = op_in[1] ? '0 : a_ext;
        end
`ifdef MULDIV_WORD_OPS_EN
        if (word_in) begin
            special_res = {{(XLEN-32){special_res[31]}}, special_res[31:0]};
        end
`endif
    end

    // One multiply step (MUL_BITS_PER_CYCLE partial products) and one restoring divide step
    always_comb begin
        mul_sum = prod_q;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (opb_q[i]) begin
                mul_sum = mul_sum + (mcand_q << i);
            end
        end
        prod_fin = neg_q ? (~mul_sum + 1'b1) : mul_sum;

        rem_sh   = {rem_q, quo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        q_bit    = ~rem_diff[XLEN];
        rem_nx   = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx   = {quo_q[XLEN-2:0], q_bit};
        quo_fin  = neg_q ? (~quo_nx + 1'b1) : quo_nx;
        rem_fin  = neg_q ? (~rem_nx + 1'b1) : rem_nx;

        if (op_q[2]) begin
            calc_res = op_q[1] ? rem_fin : quo_fin;
        end else if (op_q == OP_MUL) begin
            calc_res = prod_fin[XLEN-1:0];
        end else begin
            calc_res = prod_fin[2*XLEN-1:XLEN];
        end
`ifdef MULDIV_WORD_OPS_EN
        if (word_q) begin
            if (!op_q[2] && (op_q != OP_MUL)) begin
                calc_res = '0;
            end
            calc_res = {{(XLEN-32){calc_res[31]}}, calc_res[31:0]};
        end
`endif
    end

    // Next-state: IDLE accepts, CALC iterates, DONE waits for the consumer; flush overrides all
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
`ifdef MULDIV_WORD_OPS_EN
        word_d   = word_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    op_d    = op_in;
                    // REM follows the dividend; everything else follows s1^s2
                    neg_d   = (op_in[2] && op_in[1]) ? a_neg : (a_neg ^ b_neg);
                    mcand_d = {{XLEN{1'b0}}, a_mag};
                    opb_d   = b_mag;
                    prod_d  = '0;
                    rem_d   = '0;
                    quo_d   = quo_init;
`ifdef MULDIV_WORD_OPS_EN
                    word_d  = word_in;
`endif
                    if (div_zero || div_ovf) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        result_d = special_res;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = iter;
                    end
                end
            end
            ST_CALC: begin
                if (op_q[2]) begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                end else begin
                    prod_d  = mul_sum;
                    mcand_d = mcand_q << MUL_BITS_PER_CYCLE;
                    opb_d   = opb_q >> MUL_BITS_PER_CYCLE;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d  = ST_DONE;
                    result_d = calc_res;
                end
            end
            ST_DONE: begin
                if (ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Flush discards the op but leaves the last published result untouched
        if (flush_in) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
`ifdef MULDIV_WORD_OPS_EN
            word_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
`ifdef MULDIV_WORD_OPS_EN
            word_q   <= word_d;
`endif
        end
    end

    assign ready_out    = (state_q == ST_IDLE);
    assign busy_out     = (state_q != ST_IDLE);
    assign valid_out    = (state_q == ST_DONE);
    assign result_out   = result_q;
    assign non_zero_out = |result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=64, MUL_BITS_PER_CYCLE=1, word ops not built in).
// Expected results and latencies are queued at issue time and popped when valid_out rises.
// Also covers DONE hold under backpressure, flush mid-CALC and asynchronous reset mid-CALC.
module tb_muldiv_unit;

    logic        clk_in;
    logic        reset_n_in;
    logic        valid_in;
    logic        ready_out;
    logic [2:0]  op_in;
    logic        word_in;
    logic [63:0] rs1_value_in;
    logic [63:0] rs2_value_in;
    logic        flush_in;
    logic        valid_out;
    logic        ready_in;
    logic [63:0] result_out;
    logic        non_zero_out;
    logic        busy_out;

    int checks;
    int failures;
    logic [63:0] exp_res_q[$];
    int          exp_lat_q[$];
    logic [63:0] last_res;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    muldiv_unit #(.XLEN(64), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .op_in        (op_in),
        .word_in      (word_in),
        .rs1_value_in (rs1_value_in),
        .rs2_value_in (rs2_value_in),
        .flush_in     (flush_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .result_out   (result_out),
        .non_zero_out (non_zero_out),
        .busy_out     (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of the RV M ops on 64-bit operands
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        r;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MINV) && (b == ONES);
        r   = '0;
        case (op)
            3'd0: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0]; end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            3'd4: r = (b == 0) ? ONES : (ovf ? a : 64'(sa / sb));
            3'd5: r = (b == 0) ? ONES : (a / b);
            3'd6: r = (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
            default: r = (b == 0) ? a : (a % b);
        endcase
        return r;
    endfunction

    // Called #1 after a rising edge with the unit idle; returns #1 after an edge with the unit idle
    task automatic run_op(input string name, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat, input int hold);
        int          lat;
        logic [63:0] r;
        int          l;
        check_val({name, "/ready_in_idle"}, {63'd0, ready_out}, 64'd1);
        valid_in     = 1'b1;
        op_in        = op;
        word_in      = w;
        rs1_value_in = a;
        rs2_value_in = b;
        exp_res_q.push_back(exp_res);
        exp_lat_q.push_back(exp_lat);
        @(posedge clk_in);
        #1;
        valid_in     = 1'b0;
        op_in        = 3'($urandom_range(0, 7));
        rs1_value_in = {$urandom, $urandom};
        rs2_value_in = {$urandom, $urandom};
        lat = 0;
        while (!valid_out && lat < 300) begin
            if (lat == 3) begin
                check_val({name, "/busy_mid"}, {63'd0, busy_out}, 64'd1);
                check_val({name, "/ready_mid"}, {63'd0, ready_out}, 64'd0);
            end
            @(posedge clk_in);
            #1;
            lat++;
        end
        r = exp_res_q.pop_front();
        l = exp_lat_q.pop_front();
        check_val({name, "/latency"}, 64'(lat), 64'(l));
        check_val({name, "/result"}, result_out, r);
        check_val({name, "/non_zero"}, {63'd0, non_zero_out}, {63'd0, |r});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_in);
            #1;
            check_val({name, "/hold_valid"}, {63'd0, valid_out}, 64'd1);
            check_val({name, "/hold_result"}, result_out, r);
            check_val({name, "/hold_ready"}, {63'd0, ready_out}, 64'd0);
        end
        ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        check_val({name, "/valid_after_take"}, {63'd0, valid_out}, 64'd0);
        last_res = r;
    endtask

    // Counts valid_out pulses over a window; used after aborted ops
    task automatic expect_silence(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_in);
            #1;
            if (valid_out) seen++;
        end
        check_val({name, "/no_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [63:0] ra;
        logic [63:0] rb;
        int          rl;
        checks       = 0;
        failures     = 0;
        last_res     = '0;
        reset_n_in   = 1'b0;
        valid_in     = 1'b0;
        op_in        = '0;
        word_in      = 1'b0;
        rs1_value_in = '0;
        rs2_value_in = '0;
        flush_in     = 1'b0;
        ready_in     = 1'b0;

        repeat (3) @(posedge clk_in);
        #1;
        check_val("rst/ready", {63'd0, ready_out}, 64'd1);
        check_val("rst/valid", {63'd0, valid_out}, 64'd0);
        check_val("rst/result", result_out, 64'd0);
        check_val("rst/non_zero", {63'd0, non_zero_out}, 64'd0);
        check_val("rst/busy", {63'd0, busy_out}, 64'd0);
        reset_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Multiplies: 64 single-bit steps each
        run_op("mul_7xm3",     3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0);
        run_op("mulhu_ones",   3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0);
        run_op("mulhsu_m1x2",  3'd2, 1'b0, ONES, 64'd2, ONES, 64, 0);
        run_op("mulh_m3x5",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, ONES, 64, 0);
        run_op("mulh_2p62x4",  3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 64, 0);
        run_op("mul_zero",     3'd0, 1'b0, 64'd0, 64'h1234_5678, 64'd0, 64, 0);
        // Divides: 64 restoring steps each
        run_op("div_m7_2",     3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
        run_op("rem_m7_2",     3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 64, 0);
        run_op("divu_100_7",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 64, 0);
        run_op("remu_100_7",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 64, 5);
        run_op("rem_7_m2",     3'd6, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64, 0);
        // Special cases resolve on the accept edge
        run_op("divu_by0",     3'd5, 1'b0, 64'd13, 64'd0, ONES, 0, 0);
        run_op("remu_by0",     3'd7, 1'b0, 64'd13, 64'd0, 64'd13, 0, 0);
        run_op("div_ovf",      3'd4, 1'b0, MINV, ONES, MINV, 0, 2);
        run_op("rem_ovf",      3'd6, 1'b0, MINV, ONES, 64'd0, 0, 0);
        // word_in has no effect in this build
        run_op("mulw_ignored", 3'd0, 1'b1, 64'h1_0000_0003, 64'd2, 64'h2_0000_0006, 64, 0);

        for (int k = 0; k < 8; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = (k % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            rl  = (rop[2] && (rb == 0 || (!rop[0] && ra == MINV && rb == ONES))) ? 0 : 64;
            run_op("random", rop, 1'b0, ra, rb, model(rop, ra, rb), rl, 0);
        end

        // Flush partway through CALC
        valid_in     = 1'b1;
        op_in        = 3'd0;
        rs1_value_in = 64'd5;
        rs2_value_in = 64'd6;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clk_in);
        #1;
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        check_val("flush/ready", {63'd0, ready_out}, 64'd1);
        check_val("flush/busy", {63'd0, busy_out}, 64'd0);
        check_val("flush/valid", {63'd0, valid_out}, 64'd0);
        check_val("flush/result_kept", result_out, last_res);

        // Flush wins over a same-cycle request
        valid_in     = 1'b1;
        flush_in     = 1'b1;
        op_in        = 3'd5;
        rs1_value_in = 64'd9;
        rs2_value_in = 64'd0;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        flush_in = 1'b0;
        check_val("flush_vs_accept/busy", {63'd0, busy_out}, 64'd0);
        expect_silence("flush", 80);

        // Asynchronous reset in the middle of CALC
        valid_in     = 1'b1;
        op_in        = 3'd5;
        rs1_value_in = 64'd1000;
        rs2_value_in = 64'd3;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        reset_n_in = 1'b0;
        #1;
        check_val("arst/ready", {63'd0, ready_out}, 64'd1);
        check_val("arst/valid", {63'd0, valid_out}, 64'd0);
        check_val("arst/result", result_out, 64'd0);
        check_val("arst/non_zero", {63'd0, non_zero_out}, 64'd0);
        check_val("arst/busy", {63'd0, busy_out}, 64'd0);
        @(posedge clk_in);
        #1;
        reset_n_in = 1'b1;
        expect_silence("arst", 80);
        run_op("after_arst", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 64, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
